// File: rtl/btn_event_ctrl_if.sv
// Event handshake bundle between the button event controller
// and the downstream control FSM.
interface btn_event_ctrl_if #(
    parameter int IDW = 2
);
    logic           evt_valid;
    logic           evt_ready;
    logic [IDW-1:0] evt_id;
    logic           evt_repeat;

    modport master (
        output evt_valid,
        output evt_id,
        output evt_repeat,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_repeat,
        output evt_ready
    );
endinterface

// File: rtl/btn_event_ctrl.sv
// Button event collector: press capture, hold auto-repeat,
// round-robin arbitration onto a valid/ready event port.
module btn_event_ctrl #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int CW       = 8,
    parameter int HOLD_CYC = 50,
    parameter int REP_CYC  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     press_pulse,
    input  logic [N-1:0]     btn_level,
    input  logic             ovf_clr,
    output logic             overflow,
    btn_event_ctrl_if.master evt
);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] RELOAD    = CW'(HOLD_CYC - REP_CYC);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(N - 1);

    logic [CW-1:0]  hold_cnt [N];
    logic [N-1:0]   rep_tick;
    logic [N-1:0]   pending;
    logic [N-1:0]   pend_rep;
    logic [N-1:0]   pend_d;
    logic [N-1:0]   rep_d;
    logic [N-1:0]   clr;
    logic           ovf_set;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant;
    logic           found;
    logic           load;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            rep_tick[i] = btn_level[i] && (hold_cnt[i] == HOLD_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                hold_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!btn_level[i]) begin
                    hold_cnt[i] <= '0;
                end else if (rep_tick[i]) begin
                    hold_cnt[i] <= RELOAD;
                end else begin
                    hold_cnt[i] <= hold_cnt[i] + 1'b1;
                end
            end
        end
    end

    // First pending index at or after rr_ptr, wrapping mod N.
    always_comb begin
        int idx;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!found && pending[idx]) begin
                found = 1'b1;
                grant = IDW'(idx);
            end
        end
    end

    assign load = (!evt.evt_valid || evt.evt_ready) && found;
    assign clr  = load ? (N'(1) << grant) : '0;

    // A new set beats a same-cycle clear; only a press rewrites pend_rep.
    always_comb begin
        logic keep;
        pend_d  = '0;
        rep_d   = '0;
        ovf_set = 1'b0;
        for (int i = 0; i < N; i++) begin
            keep      = pending[i] && !clr[i];
            pend_d[i] = press_pulse[i] || rep_tick[i] || keep;
            if (press_pulse[i]) begin
                rep_d[i] = 1'b0;
            end else if (rep_tick[i] && !keep) begin
                rep_d[i] = 1'b1;
            end else begin
                rep_d[i] = pend_rep[i];
            end
            if ((press_pulse[i] || rep_tick[i]) && keep) begin
                ovf_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            pend_rep <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= pend_d;
            pend_rep <= rep_d;
            overflow <= ovf_set || (overflow && !ovf_clr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt.evt_valid  <= 1'b0;
            evt.evt_id     <= '0;
            evt.evt_repeat <= 1'b0;
            rr_ptr         <= '0;
        end else if (load) begin
            evt.evt_valid  <= 1'b1;
            evt.evt_id     <= grant;
            evt.evt_repeat <= pend_rep[grant];
            rr_ptr         <= (grant == LAST_ID) ? '0 : grant + 1'b1;
        end else if (evt.evt_ready) begin
            evt.evt_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl: press, round robin,
// auto-repeat, backpressure, set/clear overlap, reset.
module tb_btn_event_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] press_pulse;
    logic [3:0] btn_level;
    logic       ovf_clr;
    logic       overflow;
    int         total;
    int         bad;

    btn_event_ctrl_if #(.IDW(2)) evt_if ();

    btn_event_ctrl #(
        .N(4), .IDW(2), .CW(8), .HOLD_CYC(50), .REP_CYC(10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .press_pulse(press_pulse),
        .btn_level  (btn_level),
        .ovf_clr    (ovf_clr),
        .overflow   (overflow),
        .evt        (evt_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        press_pulse      = '0;
        btn_level        = '0;
        ovf_clr          = 1'b0;
        evt_if.evt_ready = 1'b1;
        do_reset();
        total++;
        if ({evt_if.evt_valid, evt_if.evt_id, evt_if.evt_repeat, overflow} !== 5'b0) begin
            bad++;
            $display("FAIL reset: got v=%b id=%0d r=%b o=%b want all 0",
                     evt_if.evt_valid, evt_if.evt_id, evt_if.evt_repeat, overflow);
        end
    endtask

    task automatic test_single_press();
        do_reset();
        evt_if.evt_ready = 1'b1;
        press_pulse = 4'b0100;
        step();
        press_pulse = '0;
        total++;
        if (evt_if.evt_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_early: valid=%b want 0", evt_if.evt_valid);
        end
        step();
        total++;
        if ({evt_if.evt_valid, evt_if.evt_id, evt_if.evt_repeat} !== {1'b1, 2'd2, 1'b0}) begin
            bad++;
            $display("FAIL single_evt: v=%b id=%0d r=%b want v=1 id=2 r=0",
                     evt_if.evt_valid, evt_if.evt_id, evt_if.evt_repeat);
        end
        step();
        total++;
        if (evt_if.evt_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drop: valid=%b want 0", evt_if.evt_valid);
        end
    endtask

    task automatic burst(input logic [1:0] e0, input logic [1:0] e1,
                         input logic [1:0] e2, input logic [1:0] e3);
        logic [1:0] exp_id [4];
        exp_id = '{e0, e1, e2, e3};
        press_pulse = 4'b1111;
        step();
        press_pulse = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== exp_id[k]) begin
                bad++;
                $display("FAIL rr_%0d: v=%b id=%0d want v=1 id=%0d",
                         k, evt_if.evt_valid, evt_if.evt_id, exp_id[k]);
            end
        end
        step();
        total++;
        if (evt_if.evt_valid !== 1'b0) begin
            bad++;
            $display("FAIL rr_end: valid=%b want 0", evt_if.evt_valid);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        evt_if.evt_ready = 1'b1;
        burst(2'd0, 2'd1, 2'd2, 2'd3);
        press_pulse = 4'b0010;
        step();
        press_pulse = '0;
        step();
        step();
        burst(2'd2, 2'd3, 2'd0, 2'd1);
    endtask

    task automatic test_auto_repeat();
        logic expv;
        do_reset();
        evt_if.evt_ready = 1'b1;
        for (int k = 0; k < 115; k++) begin
            btn_level   = (k < 75) ? 4'b0010 : 4'b0000;
            press_pulse = (k == 0) ? 4'b0010 : 4'b0000;
            step();
            expv = (k == 1) || (k == 50) || (k == 60) || (k == 70);
            total++;
            if (evt_if.evt_valid !== expv) begin
                bad++;
                $display("FAIL rep_valid_%0d: valid=%b want %b", k, evt_if.evt_valid, expv);
            end else if (expv) begin
                total++;
                if (evt_if.evt_id !== 2'd1 || evt_if.evt_repeat !== (k != 1)) begin
                    bad++;
                    $display("FAIL rep_evt_%0d: id=%0d r=%b want id=1 r=%b",
                             k, evt_if.evt_id, evt_if.evt_repeat, (k != 1));
                end
            end
        end
        btn_level   = '0;
        press_pulse = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        evt_if.evt_ready = 1'b0;
        press_pulse = 4'b1000;
        step();
        press_pulse = '0;
        step();
        total++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd3) begin
            bad++;
            $display("FAIL bp_first: v=%b id=%0d want v=1 id=3", evt_if.evt_valid, evt_if.evt_id);
        end
        press_pulse = 4'b0001;
        step();
        press_pulse = 4'b1000;
        step();
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL bp_noovf: overflow=%b want 0", overflow);
        end
        step();
        press_pulse = '0;
        total++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd3 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold: v=%b id=%0d o=%b want v=1 id=3 o=1",
                     evt_if.evt_valid, evt_if.evt_id, overflow);
        end
        evt_if.evt_ready = 1'b1;
        step();
        total++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd0 || evt_if.evt_repeat !== 1'b0) begin
            bad++;
            $display("FAIL bp_next: v=%b id=%0d r=%b want v=1 id=0 r=0",
                     evt_if.evt_valid, evt_if.evt_id, evt_if.evt_repeat);
        end
        evt_if.evt_ready = 1'b0;
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        total++;
        if (overflow !== 1'b0 || evt_if.evt_id !== 2'd0 || evt_if.evt_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_clr: o=%b v=%b id=%0d want o=0 v=1 id=0",
                     overflow, evt_if.evt_valid, evt_if.evt_id);
        end
        evt_if.evt_ready = 1'b1;
        step();
        total++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd3) begin
            bad++;
            $display("FAIL bp_drain: v=%b id=%0d want v=1 id=3", evt_if.evt_valid, evt_if.evt_id);
        end
        step();
        total++;
        if (evt_if.evt_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_empty: valid=%b want 0", evt_if.evt_valid);
        end
    endtask

    task automatic test_set_clear();
        do_reset();
        evt_if.evt_ready = 1'b1;
        press_pulse = 4'b0010;
        step();
        step();
        press_pulse = '0;
        total++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd1) begin
            bad++;
            $display("FAIL sc_first: v=%b id=%0d want v=1 id=1", evt_if.evt_valid, evt_if.evt_id);
        end
        step();
        total++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd1 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL sc_second: v=%b id=%0d o=%b want v=1 id=1 o=0",
                     evt_if.evt_valid, evt_if.evt_id, overflow);
        end
        step();
        total++;
        if (evt_if.evt_valid !== 1'b0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL sc_end: v=%b o=%b want v=0 o=0", evt_if.evt_valid, overflow);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        evt_if.evt_ready = 1'b0;
        press_pulse = 4'b1011;
        step();
        press_pulse = 4'b0001;
        step();
        press_pulse = 4'b1000;
        step();
        press_pulse = '0;
        total++;
        if (evt_if.evt_valid !== 1'b1 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL mr_pre: v=%b o=%b want v=1 o=1", evt_if.evt_valid, overflow);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({evt_if.evt_valid, evt_if.evt_id, evt_if.evt_repeat, overflow} !== 5'b0) begin
            bad++;
            $display("FAIL mr_async: v=%b id=%0d r=%b o=%b want all 0",
                     evt_if.evt_valid, evt_if.evt_id, evt_if.evt_repeat, overflow);
        end
        step();
        rst_n = 1'b1;
        evt_if.evt_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            total++;
            if (evt_if.evt_valid !== 1'b0) begin
                bad++;
                $display("FAIL mr_quiet_%0d: valid=%b want 0", k, evt_if.evt_valid);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        test_reset();
        test_single_press();
        test_round_robin();
        test_auto_repeat();
        test_backpressure();
        test_set_clear();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
